// File: rtl/seg7_scan_mux.sv
// Eight-digit multiplexed 7-segment driver with frame-synchronous double buffering and
// frame-counted blinking; all outputs are registered.
module seg7_scan_mux #(
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  digit_idx_i,
   input  logic        load_i,
   input  logic [31:0] bcd_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  blink_mask_i,
   input  logic [7:0]  blank_mask_i,
   output logic [7:0]  an_n_o,
   output logic [6:0]  seg_n_o,
   output logic        dp_n_o
);

   localparam logic [7:0] FrameLast = 8'(BLINK_FRAMES - 1);

   logic [2:0]  idx_q;
   logic [31:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
   logic [7:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [7:0]  pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
   logic [7:0]  pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic        pend_valid_q, pend_valid_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        phase_q, phase_d;
   logic [7:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;

   logic       boundary, commit, blanked;
   logic [3:0] nibble;
   logic [6:0] seg_dec;

   always_comb begin
      boundary = (idx_q == 3'd7) && (digit_idx_i == 3'd0);
      commit   = boundary & pend_valid_q;

      act_bcd_d   = commit ? pend_bcd_q   : act_bcd_q;
      act_dp_d    = commit ? pend_dp_q    : act_dp_q;
      act_blink_d = commit ? pend_blink_q : act_blink_q;
      act_blank_d = commit ? pend_blank_q : act_blank_q;

      // A load on a boundary lands in pending after the old pending has been committed.
      pend_bcd_d   = load_i ? bcd_i        : pend_bcd_q;
      pend_dp_d    = load_i ? dp_i         : pend_dp_q;
      pend_blink_d = load_i ? blink_mask_i : pend_blink_q;
      pend_blank_d = load_i ? blank_mask_i : pend_blank_q;
      pend_valid_d = load_i | (pend_valid_q & ~boundary);

      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (boundary) begin
         if (frame_cnt_q == FrameLast) begin
            frame_cnt_d = 8'd0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   // Decode from the post-commit view so the first digit of a frame is already current.
   always_comb begin
      nibble  = act_bcd_d[{digit_idx_i, 2'b00} +: 4];
      blanked = act_blank_d[digit_idx_i] | (phase_d & act_blink_d[digit_idx_i]);
      case (nibble)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;
      endcase
      an_d  = blanked ? 8'hFF : ~(8'b1 << digit_idx_i);
      seg_d = blanked ? 7'h7F : seg_dec;
      dp_d  = blanked ? 1'b1  : ~act_dp_d[digit_idx_i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q        <= 3'd0;
         pend_bcd_q   <= 32'd0;
         pend_dp_q    <= 8'd0;
         pend_blink_q <= 8'd0;
         pend_blank_q <= 8'd0;
         pend_valid_q <= 1'b0;
         act_bcd_q    <= 32'd0;
         act_dp_q     <= 8'd0;
         act_blink_q  <= 8'd0;
         act_blank_q  <= 8'hFF;
         frame_cnt_q  <= 8'd0;
         phase_q      <= 1'b0;
         an_q         <= 8'hFF;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
      end else begin
         idx_q        <= digit_idx_i;
         pend_bcd_q   <= pend_bcd_d;
         pend_dp_q    <= pend_dp_d;
         pend_blink_q <= pend_blink_d;
         pend_blank_q <= pend_blank_d;
         pend_valid_q <= pend_valid_d;
         act_bcd_q    <= act_bcd_d;
         act_dp_q     <= act_dp_d;
         act_blink_q  <= act_blink_d;
         act_blank_q  <= act_blank_d;
         frame_cnt_q  <= frame_cnt_d;
         phase_q      <= phase_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign an_n_o  = an_q;
   assign seg_n_o = seg_q;
   assign dp_n_o  = dp_q;

endmodule
